alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that borrows the shared execute-stage ALU to perform 32-bit unsigned multiply (shift-add) and unsigned divide (restoring).
- While it owns the ALU it drives the ALU operand and control inputs, and steers them through the execute-stage operand mux via o_ALU_Own.
- It consumes the ALU's combinational result and carry/borrow.
- It stalls the pipeline via o_Busy until it returns the result.

---
 rtl/alu_muldiv_seq_if.sv | 40 ++++
 rtl/alu_muldiv_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// alu_muldiv_seq_if : pipeline/ALU-side bus of the multi-cycle mul/div sequencer
// Rev 1.0
// ============================================================================
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_Start;
  logic             i_Div;
  logic [WIDTH-1:0] i_Op1;
  logic [WIDTH-1:0] i_Op2;
  logic             i_Flush;
  logic [WIDTH-1:0] i_ALU_rslt;
  logic             i_ALU_Carry;
  logic             o_ALU_Own;
  logic [WIDTH-1:0] o_ALU_Op1;
  logic [WIDTH-1:0] o_ALU_Op2;
  logic [2:0]       o_ALU_Ctrl;
  logic             o_Busy;
  logic             o_Done;
  logic [WIDTH-1:0] o_Rslt;
  logic [WIDTH-1:0] o_Rem;
  logic             o_DivZero;

  // Execute stage / ALU side
  modport master (
    output i_Start, i_Div, i_Op1, i_Op2, i_Flush, i_ALU_rslt, i_ALU_Carry,
    input  o_ALU_Own, o_ALU_Op1, o_ALU_Op2, o_ALU_Ctrl,
    input  o_Busy, o_Done, o_Rslt, o_Rem, o_DivZero
  );

  // Sequencer side
  modport slave (
    input  i_Start, i_Div, i_Op1, i_Op2, i_Flush, i_ALU_rslt, i_ALU_Carry,
    output o_ALU_Own, o_ALU_Op1, o_ALU_Op2, o_ALU_Ctrl,
    output o_Busy, o_Done, o_Rslt, o_Rem, o_DivZero
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// alu_muldiv_seq : borrows the shared ALU for shift-add multiply / restoring divide
// Rev 1.0
// ============================================================================
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input wire                clk,
  input wire                reset,
  alu_muldiv_seq_if.slave   io_bus
);

  localparam int               CNT_W       = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [2:0]       C_ALU_NOP   = 3'b000;
  localparam logic [2:0]       C_ALU_ADD   = 3'b001;
  localparam logic [2:0]       C_ALU_SUB   = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_rslt;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_divzero;

  logic             w_start;
  logic             w_last;
  logic             w_op2_zero;
  logic [WIDTH:0]   w_part;
  logic             w_sub_ok;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quot_nxt;

  logic             w_own;
  logic [WIDTH-1:0] w_alu_op1;
  logic [WIDTH-1:0] w_alu_op2;
  logic [2:0]       w_alu_ctrl;
  logic             w_busy;
  logic             w_done;

  // A flush in IDLE drops a coincident start request.
  assign w_start    = io_bus.i_Start & ~io_bus.i_Flush;
  assign w_last     = (r_cnt == C_LAST_STEP);
  assign w_op2_zero = (io_bus.i_Op2 == '0);

  // Restoring divide: when the partial's top bit is set it already exceeds the
  // divisor, so the subtraction is taken regardless of the 32-bit borrow.
  assign w_part     = {r_rem, r_quot[WIDTH-1]};
  assign w_sub_ok   = w_part[WIDTH] | ~io_bus.i_ALU_Carry;
  assign w_rem_nxt  = w_sub_ok ? io_bus.i_ALU_rslt : w_part[WIDTH-1:0];
  assign w_quot_nxt = {r_quot[WIDTH-2:0], w_sub_ok};
  assign w_acc_nxt  = r_mplier[0] ? io_bus.i_ALU_rslt : r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_own       = 1'b0;
    w_alu_op1   = '0;
    w_alu_op2   = '0;
    w_alu_ctrl  = C_ALU_NOP;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (!io_bus.i_Div) begin
            w_state_nxt = S_MUL;
          end else if (w_op2_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL: begin
        w_own      = 1'b1;
        w_alu_op1  = r_acc;
        w_alu_op2  = r_mcand;
        w_alu_ctrl = C_ALU_ADD;
        w_busy     = 1'b1;
        if (io_bus.i_Flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DIV: begin
        w_own      = 1'b1;
        w_alu_op1  = w_part[WIDTH-1:0];
        w_alu_op2  = r_dvsr;
        w_alu_ctrl = C_ALU_SUB;
        w_busy     = 1'b1;
        if (io_bus.i_Flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Results are written only on completion so a flushed op leaves them intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
      r_rslt    <= '0;
      r_rem_out <= '0;
      r_divzero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt <= '0;
            if (!io_bus.i_Div) begin
              r_acc     <= '0;
              r_mcand   <= io_bus.i_Op1;
              r_mplier  <= io_bus.i_Op2;
              r_divzero <= 1'b0;
            end else if (w_op2_zero) begin
              r_rslt    <= '1;
              r_rem_out <= io_bus.i_Op1;
              r_divzero <= 1'b1;
            end else begin
              r_quot    <= io_bus.i_Op1;
              r_rem     <= '0;
              r_dvsr    <= io_bus.i_Op2;
              r_divzero <= 1'b0;
            end
          end
        end
        S_MUL: begin
          if (!io_bus.i_Flush) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              r_rslt    <= w_acc_nxt;
              r_rem_out <= '0;
            end
          end
        end
        S_DIV: begin
          if (!io_bus.i_Flush) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_rslt    <= w_quot_nxt;
              r_rem_out <= w_rem_nxt;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.o_ALU_Own  = w_own;
  assign io_bus.o_ALU_Op1  = w_alu_op1;
  assign io_bus.o_ALU_Op2  = w_alu_op2;
  assign io_bus.o_ALU_Ctrl = w_alu_ctrl;
  assign io_bus.o_Busy     = w_busy;
  assign io_bus.o_Done     = w_done;
  assign io_bus.o_Rslt     = r_rslt;
  assign io_bus.o_Rem      = r_rem_out;
  assign io_bus.o_DivZero  = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_muldiv_seq : scoreboard bench with a behavioural ALU for alu_muldiv_seq
// Rev 1.0
// ============================================================================
module tb_alu_muldiv_seq;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] rslt;
    logic [WIDTH-1:0] rem;
    logic             dz;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  logic [WIDTH-1:0] last_rslt;
  logic [WIDTH-1:0] last_rem;
  logic             last_dz;
  logic [WIDTH:0]   w_alu_wide;

  alu_muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execute-stage ALU: 33-bit add/sub so bit 32 is the raw carry/borrow
  always_comb begin
    w_alu_wide = '0;
    case (bus.o_ALU_Ctrl)
      3'b001:  w_alu_wide = {1'b0, bus.o_ALU_Op1} + {1'b0, bus.o_ALU_Op2};
      3'b010:  w_alu_wide = {1'b0, bus.o_ALU_Op1} - {1'b0, bus.o_ALU_Op2};
      default: w_alu_wide = '0;
    endcase
  end
  assign bus.i_ALU_rslt  = w_alu_wide[WIDTH-1:0];
  assign bus.i_ALU_Carry = w_alu_wide[WIDTH];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, 64'(bus.o_Busy), 64'd0);
    check_val({tag, "_own"},  64'(bus.o_ALU_Own), 64'd0);
    check_val({tag, "_op1"},  64'(bus.o_ALU_Op1), 64'd0);
    check_val({tag, "_op2"},  64'(bus.o_ALU_Op2), 64'd0);
    check_val({tag, "_ctrl"}, 64'(bus.o_ALU_Ctrl), 64'd0);
    check_val({tag, "_done"}, 64'(bus.o_Done), 64'd0);
  endtask

  // Issues one op, optionally pulses a competing start at cycle intf_at,
  // and scores the result against the reference model.
  task automatic run_op(input logic div, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int intf_at);
    exp_t       e;
    exp_t       got_e;
    int         cyc;
    int         busy_n;
    int         own_n;
    int         bad_n;
    int         exp_lat;
    logic [2:0] exp_ctrl;
    if (!div) begin
      e.rslt = a * b;
      e.rem  = '0;
      e.dz   = 1'b0;
    end else if (b == '0) begin
      e.rslt = '1;
      e.rem  = a;
      e.dz   = 1'b1;
    end else begin
      e.rslt = a / b;
      e.rem  = a % b;
      e.dz   = 1'b0;
    end
    sb.push_back(e);
    exp_lat  = (div && b == '0) ? 1 : WIDTH + 1;
    exp_ctrl = div ? 3'b010 : 3'b001;

    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Div   = div;
    bus.i_Op1   = a;
    bus.i_Op2   = b;
    @(negedge clk);
    bus.i_Start = 1'b0;
    cyc    = 1;
    busy_n = 0;
    own_n  = 0;
    bad_n  = 0;
    while (!bus.o_Done && cyc < 60) begin
      if (bus.o_Busy) begin
        busy_n++;
        if (bus.o_ALU_Ctrl != exp_ctrl || !bus.o_ALU_Own) bad_n++;
      end
      if (bus.o_ALU_Own) own_n++;
      if (cyc == 1) begin
        check_val("first_op1", 64'(bus.o_ALU_Op1), div ? 64'(a[WIDTH-1]) : 64'd0);
        check_val("first_op2", 64'(bus.o_ALU_Op2), 64'(div ? b : a));
      end
      if (cyc == intf_at) begin
        bus.i_Start = 1'b1;
        bus.i_Div   = ~div;
        bus.i_Op1   = 32'h0000_0055;
        bus.i_Op2   = 32'h0000_0003;
      end else begin
        bus.i_Start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_Start = 1'b0;
    check_val("done_seen",   64'(bus.o_Done), 64'd1);
    check_val("latency",     64'(cyc), 64'(exp_lat));
    check_val("busy_cycles", 64'(busy_n), 64'(exp_lat - 1));
    check_val("own_cycles",  64'(own_n), 64'(exp_lat - 1));
    check_val("ctrl_own",    64'(bad_n), 64'd0);
    check_val("done_busy",   64'(bus.o_Busy), 64'd0);
    if (bus.o_Done) begin
      got_e = sb.pop_front();
      check_val("rslt",    64'(bus.o_Rslt), 64'(got_e.rslt));
      check_val("rem",     64'(bus.o_Rem), 64'(got_e.rem));
      check_val("divzero", 64'(bus.o_DivZero), 64'(got_e.dz));
      last_rslt = got_e.rslt;
      last_rem  = got_e.rem;
      last_dz   = got_e.dz;
    end
    @(negedge clk);
    check_val("done_pulse", 64'(bus.o_Done), 64'd0);
    check_val("held_rslt",  64'(bus.o_Rslt), 64'(last_rslt));
  endtask

  // Aborts an op at cycle flush_at; results must keep their previous values.
  task automatic flush_op(input logic div, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int flush_at);
    int done_n;
    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Div   = div;
    bus.i_Op1   = a;
    bus.i_Op2   = b;
    @(negedge clk);
    bus.i_Start = 1'b0;
    repeat (flush_at - 1) @(negedge clk);
    check_val("flush_pre_busy", 64'(bus.o_Busy), 64'd1);
    bus.i_Flush = 1'b1;
    @(negedge clk);
    bus.i_Flush = 1'b0;
    check_idle_outputs("flush_after");
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_Done) done_n++;
    end
    check_val("flush_no_done", 64'(done_n), 64'd0);
    check_val("flush_rslt",    64'(bus.o_Rslt), 64'(last_rslt));
    check_val("flush_rem",     64'(bus.o_Rem), 64'(last_rem));
    // The accepted start cleared the divide-by-zero flag.
    last_dz = 1'b0;
    check_val("flush_dz",      64'(bus.o_DivZero), 64'(last_dz));
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rd;
    int               done_n;
    n_checks    = 0;
    n_errors    = 0;
    last_rslt   = '0;
    last_rem    = '0;
    last_dz     = 1'b0;
    reset       = 1'b1;
    bus.i_Start = 1'b0;
    bus.i_Div   = 1'b0;
    bus.i_Op1   = '0;
    bus.i_Op2   = '0;
    bus.i_Flush = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_val("reset_rslt", 64'(bus.o_Rslt), 64'd0);
    check_val("reset_rem",  64'(bus.o_Rem), 64'd0);
    check_val("reset_dz",   64'(bus.o_DivZero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd7, 32'd6, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(1'b1, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(1'b1, 32'h0000_1234, 32'h0000_0000, 0);

    // Flush and start together in IDLE: start is dropped, flags untouched
    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Flush = 1'b1;
    bus.i_Div   = 1'b0;
    bus.i_Op1   = 32'd3;
    bus.i_Op2   = 32'd4;
    @(negedge clk);
    bus.i_Start = 1'b0;
    bus.i_Flush = 1'b0;
    check_idle_outputs("idle_flush");
    done_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_Done || bus.o_Busy) done_n++;
    end
    check_val("idle_flush_quiet", 64'(done_n), 64'd0);
    check_val("idle_flush_dz",    64'(bus.o_DivZero), 64'(last_dz));
    check_val("idle_flush_rslt",  64'(bus.o_Rslt), 64'(last_rslt));

    run_op(1'b0, 32'd7, 32'd6, 5);
    flush_op(1'b0, 32'h0000_1234, 32'd5, 10);

    // Asynchronous reset between clock edges in the middle of a divide
    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Div   = 1'b1;
    bus.i_Op1   = 32'd100;
    bus.i_Op2   = 32'd7;
    @(negedge clk);
    bus.i_Start = 1'b0;
    repeat (10) @(negedge clk);
    check_val("pre_reset_busy", 64'(bus.o_Busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check_val("async_reset_rslt", 64'(bus.o_Rslt), 64'd0);
    check_val("async_reset_rem",  64'(bus.o_Rem), 64'd0);
    check_val("async_reset_dz",   64'(bus.o_DivZero), 64'd0);
    last_rslt = '0;
    last_rem  = '0;
    last_dz   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b1, 32'd100, 32'd7, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 4) ? 32'd0 : (((i % 2) == 1) ? ($urandom >> (i * 4)) : $urandom);
      rd = (i % 2 == 1) || (i == 4);
      run_op(rd, ra, rb, 0);
    end

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
